lvds_tx_sequencer: RTL

Word-level sequencer for the LVDS TX serializer. It paces I/Q samples from the signal generator into 32-bit framed LVDS words, inserts zero-padding words between samples according to a programmable skip count, and emits a tail word at end of message or on abort. All decisions are taken at serializer word boundaries, marked by i_word_strobe.

---
 rtl/lvds_tx_sequencer_if.sv | 33 +++
 rtl/lvds_tx_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_sequencer_if.sv
// Word-level handshake bundle between the LVDS TX sequencer, the sample generator and the
// serializer. The master drives the request side and the slave is the sequencer.
interface lvds_tx_sequencer_if #(
  parameter int unsigned SAMPLE_W = 13,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned UND_W    = 16
);
  logic                i_word_strobe;
  logic                i_start;
  logic                i_abort;
  logic [CNT_W-1:0]    i_skip;
  logic [SAMPLE_W-1:0] i_sample_i;
  logic [SAMPLE_W-1:0] i_sample_q;
  logic                i_sample_last;
  logic                i_sample_valid;
  logic                o_sample_req;
  logic [31:0]         o_tx_data;
  logic                o_busy;
  logic                o_done;
  logic [UND_W-1:0]    o_underrun_count;

  modport master (
    output i_word_strobe, i_start, i_abort, i_skip, i_sample_i, i_sample_q, i_sample_last,
           i_sample_valid,
    input  o_sample_req, o_tx_data, o_busy, o_done, o_underrun_count
  );

  modport slave (
    input  i_word_strobe, i_start, i_abort, i_skip, i_sample_i, i_sample_q, i_sample_last,
           i_sample_valid,
    output o_sample_req, o_tx_data, o_busy, o_done, o_underrun_count
  );
endinterface

// File: rtl/lvds_tx_sequencer.sv
// Paces I/Q samples into framed 32-bit LVDS words with zero padding and a tail word.
// Optional underrun counter enabled by defining LVDS_TX_UNDERRUN_COUNT_EN.
module lvds_tx_sequencer #(
  parameter int unsigned SAMPLE_W = 13,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned UND_W    = 16
) (
  input logic                clk,
  input logic                reset,
  lvds_tx_sequencer_if.slave tx_io
);
  localparam logic [31:0] TailWord = {2'b10, 14'b0, 2'b01, 14'b0};

  typedef enum logic [1:0] {StIdle, StPrepare, StTransmit} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         tx_q, tx_d;
  logic                req_q, req_d;
  logic                done_q, done_d;
  logic                start_q;
  logic                armed_q, armed_d;
  logic                pend_q, pend_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hold_i_q, hold_q_q;
  logic                hold_last_q;
  logic                last_sent_q, last_sent_d;
  logic                accept, avail, clear_hold, go_idle;
  logic [SAMPLE_W-1:0] smp_i, smp_q;
  logic                smp_last;

  // Valids are only taken while a request is outstanding; bypass serves same-cycle strobes.
  assign accept   = tx_io.i_sample_valid && (req_q || pend_q);
  assign avail    = hold_full_q || accept;
  assign smp_i    = hold_full_q ? hold_i_q    : tx_io.i_sample_i;
  assign smp_q    = hold_full_q ? hold_q_q    : tx_io.i_sample_q;
  assign smp_last = hold_full_q ? hold_last_q : tx_io.i_sample_last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    req_d       = 1'b0;
    done_d      = 1'b0;
    armed_d     = armed_q;
    last_sent_d = last_sent_q;
    clear_hold  = 1'b0;
    go_idle     = 1'b0;
    if ((state_q == StIdle) && tx_io.i_start && !start_q) armed_d = 1'b1;
    if (tx_io.i_word_strobe) begin
      unique case (state_q)
        StIdle: begin
          tx_d = '0;
          if (armed_q) begin
            armed_d = 1'b0;
            cnt_d   = '0;
            state_d = StPrepare;
            req_d   = 1'b1;
          end
        end
        StPrepare: begin
          if (tx_io.i_abort) begin
            go_idle = 1'b1;
          end else if (cnt_q < tx_io.i_skip) begin
            tx_d  = '0;
            cnt_d = cnt_q + 1'b1;
          end else if (avail) begin
            tx_d        = {2'b10, smp_i, 1'b1, 2'b01, smp_q, 1'b0};
            clear_hold  = 1'b1;
            last_sent_d = smp_last;
            state_d     = StTransmit;
          end else begin
            tx_d = '0;
          end
        end
        StTransmit: begin
          if (tx_io.i_abort || last_sent_q) begin
            go_idle = 1'b1;
          end else begin
            tx_d    = '0;
            cnt_d   = '0;
            state_d = StPrepare;
            req_d   = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (go_idle) begin
      tx_d       = TailWord;
      done_d     = 1'b1;
      clear_hold = 1'b1;
      state_d    = StIdle;
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    pend_d      = pend_q;
    if (req_q) pend_d = 1'b1;
    if (accept) pend_d = 1'b0;
    if (go_idle) pend_d = 1'b0;
    if (clear_hold) hold_full_d = 1'b0;
    else if (accept) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tx_q        <= '0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
      pend_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      hold_last_q <= 1'b0;
      last_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      req_q       <= req_d;
      done_q      <= done_d;
      start_q     <= tx_io.i_start;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      hold_full_q <= hold_full_d;
      last_sent_q <= last_sent_d;
      if (accept && !clear_hold) begin
        hold_i_q    <= tx_io.i_sample_i;
        hold_q_q    <= tx_io.i_sample_q;
        hold_last_q <= tx_io.i_sample_last;
      end
    end
  end

  assign tx_io.o_tx_data    = tx_q;
  assign tx_io.o_sample_req = req_q;
  assign tx_io.o_done       = done_q;
  assign tx_io.o_busy       = (state_q != StIdle);

`ifdef LVDS_TX_UNDERRUN_COUNT_EN
  logic             underrun;
  logic [UND_W-1:0] und_q;

  assign underrun = tx_io.i_word_strobe && (state_q == StPrepare) && !tx_io.i_abort &&
                    (cnt_q >= tx_io.i_skip) && !avail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      und_q <= '0;
    end else if (underrun && (und_q != '1)) begin
      und_q <= und_q + 1'b1;
    end
  end

  assign tx_io.o_underrun_count = und_q;
`else
  assign tx_io.o_underrun_count = '0;
`endif
endmodule
